// File: rtl/note_sequencer.sv
// Three-lane rhythm-game chart sequencer: loads a song chart, steps it out
// at a fixed tick rate and presents the current note plus a 8-step look-ahead.
module note_sequencer #(
   parameter int TICK_DIV  = 5000000,
   parameter int CHART_LEN = 100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           song_select,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 pause,
   input  logic [CHART_LEN-1:0] chart_red,
   input  logic [CHART_LEN-1:0] chart_blue,
   input  logic [CHART_LEN-1:0] chart_yellow,
   output logic [4:0]           song_sel_out,
   output logic                 hit_red,
   output logic                 hit_blue,
   output logic                 hit_yellow,
   output logic [7:0]           win_red,
   output logic [7:0]           win_blue,
   output logic [7:0]           win_yellow,
   output logic                 step_pulse,
   output logic [6:0]           steps_left,
   output logic [1:0]           state,
   output logic                 done
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [4:0]           sel_q, sel_d;
   logic [CHART_LEN-1:0] red_q, red_d, blue_q, blue_d, yel_q, yel_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [6:0]           steps_q, steps_d;
   logic                 pulse_q, pulse_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         red_q   <= '0;
         blue_q  <= '0;
         yel_q   <= '0;
         tick_q  <= '0;
         steps_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         red_q   <= red_d;
         blue_q  <= blue_d;
         yel_q   <= yel_d;
         tick_q  <= tick_d;
         steps_q <= steps_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      red_d   = red_q;
      blue_d  = blue_q;
      yel_d   = yel_q;
      tick_d  = tick_q;
      steps_d = steps_q;
      pulse_d = 1'b0;
      // stop outranks everything, including a wrap landing on the same edge
      if (stop) begin
         state_d = IDLE;
         red_d   = '0;
         blue_d  = '0;
         yel_d   = '0;
         tick_d  = '0;
         steps_d = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d = LOAD;
                  sel_d   = song_select;
               end
            end
            LOAD: begin
               state_d = PLAY;
               red_d   = chart_red;
               blue_d  = chart_blue;
               yel_d   = chart_yellow;
               tick_d  = '0;
               steps_d = 7'(CHART_LEN);
            end
            PLAY: begin
               if (!pause) begin
                  if (tick_q == TICK_MAX) begin
                     tick_d  = '0;
                     red_d   = {red_q[CHART_LEN-2:0], 1'b0};
                     blue_d  = {blue_q[CHART_LEN-2:0], 1'b0};
                     yel_d   = {yel_q[CHART_LEN-2:0], 1'b0};
                     steps_d = steps_q - 7'd1;
                     pulse_d = 1'b1;
                     if (steps_q == 7'd1) begin
                        state_d = DONE;
                        red_d   = '0;
                        blue_d  = '0;
                        yel_d   = '0;
                     end
                  end else begin
                     tick_d = tick_q + TW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign song_sel_out = sel_q;
   assign hit_red      = red_q[CHART_LEN-1];
   assign hit_blue     = blue_q[CHART_LEN-1];
   assign hit_yellow   = yel_q[CHART_LEN-1];
   assign win_red      = red_q[CHART_LEN-1 -: 8];
   assign win_blue     = blue_q[CHART_LEN-1 -: 8];
   assign win_yellow   = yel_q[CHART_LEN-1 -: 8];
   assign step_pulse   = pulse_q;
   assign steps_left   = steps_q;
   assign state        = state_q;
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed table, hand sequences for timing corners,
// and random stimulus checked every cycle against a step-count reference model.
module tb_note_sequencer;
   localparam int TICK = 4;
   localparam int CL   = 100;

   logic          clk, reset, start, stop, pause;
   logic [4:0]    song_select, song_sel_out;
   logic [CL-1:0] chart_red, chart_blue, chart_yellow;
   logic          hit_red, hit_blue, hit_yellow, step_pulse, done;
   logic [7:0]    win_red, win_blue, win_yellow;
   logic [6:0]    steps_left;
   logic [1:0]    state;

   note_sequencer #(.TICK_DIV(TICK), .CHART_LEN(CL)) dut (
      .clk(clk), .reset(reset), .song_select(song_select), .start(start),
      .stop(stop), .pause(pause), .chart_red(chart_red), .chart_blue(chart_blue),
      .chart_yellow(chart_yellow), .song_sel_out(song_sel_out),
      .hit_red(hit_red), .hit_blue(hit_blue), .hit_yellow(hit_yellow),
      .win_red(win_red), .win_blue(win_blue), .win_yellow(win_yellow),
      .step_pulse(step_pulse), .steps_left(steps_left), .state(state), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: which chart step we are on, and active cycles since the last step.
   int            m_st = 0;
   int            m_k = 0;
   int            m_ph = 0;
   bit            m_pulse = 0;
   logic [4:0]    m_sel = '0;
   logic [CL-1:0] mr = '0, mb = '0, my = '0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic lane(input logic [CL-1:0] c, input int idx);
      return (m_st == 2 && idx >= 0) ? c[idx] : 1'b0;
   endfunction

   function automatic logic [7:0] lwin(input logic [CL-1:0] c);
      logic [7:0] w;
      for (int j = 0; j < 8; j++) w[7-j] = lane(c, CL - 1 - m_k - j);
      return w;
   endfunction

   function automatic logic [42:0] exp_vec();
      logic [6:0] sl;
      sl = (m_st == 2) ? 7'(CL - m_k) : 7'd0;
      return {2'(m_st), (m_st == 3), m_pulse, sl,
              lane(mr, CL-1-m_k), lane(mb, CL-1-m_k), lane(my, CL-1-m_k),
              lwin(mr), lwin(mb), lwin(my), m_sel};
   endfunction

   function automatic logic [42:0] dut_vec();
      return {state, done, step_pulse, steps_left, hit_red, hit_blue, hit_yellow,
              win_red, win_blue, win_yellow, song_sel_out};
   endfunction

   task automatic model_edge();
      m_pulse = 0;
      if (reset) begin
         m_st = 0; m_sel = '0; m_k = 0; m_ph = 0;
      end else if (stop) begin
         m_st = 0; m_k = 0; m_ph = 0;
      end else begin
         case (m_st)
            0, 3: if (start) begin m_st = 1; m_sel = song_select; end
            1: begin
               m_st = 2; m_k = 0; m_ph = 0;
               mr = chart_red; mb = chart_blue; my = chart_yellow;
            end
            default: if (!pause) begin
               m_ph++;
               if (m_ph == TICK) begin
                  m_ph = 0; m_k++; m_pulse = 1;
                  if (m_k == CL) m_st = 3;
               end
            end
         endcase
      end
   endtask

   task automatic tick(input string nm);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk(nm, 64'(dut_vec()), 64'(exp_vec()));
   endtask

   task automatic play_to_done(input string nm, output int np, output int first_hit,
                               output logic [7:0] win8);
      np = 0; first_hit = -1; win8 = '0;
      for (int c = 0; c < 600 && state != 2'd3; c++) begin
         tick(nm);
         if (step_pulse) begin
            np++;
            if (np == 8) win8 = win_red;
         end
         if (hit_red && first_hit < 0) first_hit = np;
      end
      chk({nm, "_done"}, 64'(state), 64'd3);
   endtask

   typedef struct {
      logic       start, stop, pause;
      logic [4:0] sel;
      int         extra;
      logic [1:0] st;
      logic [6:0] steps;
      logic [4:0] osel;
   } vec_t;

   vec_t tbl[7];
   int np, fh, n;
   logic [7:0] w8;

   initial begin
      reset = 1'b1; start = 0; stop = 0; pause = 0; song_select = '0;
      chart_red = '0; chart_blue = '0; chart_yellow = '0;
      tick("reset");
      chk("reset_zero", 64'(dut_vec()), 64'd0);
      reset = 1'b0;
      chart_red = 100'h1;

      tbl[0] = '{1, 0, 0, 5'h0F, 0, 2'd1, 7'd0,   5'h0F};
      tbl[1] = '{0, 0, 0, 5'h0F, 0, 2'd2, 7'd100, 5'h0F};
      tbl[2] = '{1, 0, 0, 5'h03, 0, 2'd2, 7'd100, 5'h0F};
      tbl[3] = '{0, 0, 0, 5'h03, 2, 2'd2, 7'd99,  5'h0F};
      tbl[4] = '{0, 0, 1, 5'h03, 0, 2'd2, 7'd99,  5'h0F};
      tbl[5] = '{1, 1, 1, 5'h07, 0, 2'd0, 7'd0,   5'h0F};
      tbl[6] = '{1, 0, 0, 5'h12, 1, 2'd2, 7'd100, 5'h12};
      for (int i = 0; i < 7; i++) begin
         start = tbl[i].start; stop = tbl[i].stop; pause = tbl[i].pause;
         song_select = tbl[i].sel;
         tick("tbl_step");
         start = 0; stop = 0; pause = 0;
         repeat (tbl[i].extra) tick("tbl_step");
         chk($sformatf("tbl%0d", i), 64'({state, steps_left, song_sel_out}),
             64'({tbl[i].st, tbl[i].steps, tbl[i].osel}));
      end
      stop = 1; tick("stop_clean"); stop = 0;

      // Basic play: single note at the last chart step
      song_select = 5'h0F; start = 1; tick("basic"); start = 0; tick("basic");
      chk("basic_play_lat", 64'(state), 64'd2);
      play_to_done("basic", np, fh, w8);
      chk("basic_pulses", 64'(np), 64'd100);
      chk("basic_first_hit", 64'(fh), 64'd99);

      // Lead-in: first note at bit 89, then restart from DONE with a new song code
      chart_red = 100'h0; chart_red[89] = 1'b1; chart_blue = 100'h5; chart_yellow = {100{1'b1}};
      song_select = 5'h05; start = 1; tick("lead"); start = 0; tick("lead");
      play_to_done("lead", np, fh, w8);
      chk("lead_first_hit", 64'(fh), 64'd10);
      chk("lead_win8", 64'(w8), 64'h20);
      song_select = 5'h1A; start = 1; tick("restart"); start = 0;
      chk("restart_load", 64'({state, song_sel_out}), 64'({2'd1, 5'h1A}));
      song_select = 5'h01;
      tick("restart");

      // Pause at tick count 2 for 10 cycles
      tick("pause"); tick("pause");
      chk("pause_phase", 64'(m_ph), 64'd2);
      pause = 1; n = 0;
      repeat (10) begin tick("pause_hold"); if (step_pulse) n++; end
      chk("pause_no_pulse", 64'(n), 64'd0);
      chk("pause_steps", 64'(steps_left), 64'd100);
      pause = 0; n = 0;
      for (int c = 1; c <= 10 && n == 0; c++) begin tick("pause_rel"); if (step_pulse) n = c; end
      chk("pause_resume", 64'(n), 64'd2);

      // Stop coinciding with the wrap at steps_left=50
      for (int c = 0; c < 400 && !(m_st == 2 && CL - m_k == 50 && m_ph == TICK - 1); c++)
         tick("stop_seek");
      chk("stop_seek_ok", 64'(steps_left), 64'd50);
      stop = 1; tick("stop"); stop = 0;
      chk("stop_wrap", 64'({state, steps_left, step_pulse}), 64'd0);

      // Async reset mid-PLAY, checked before the next clock edge
      start = 1; tick("arst"); start = 0;
      repeat (10) tick("arst");
      #2 reset = 1;
      #1 chk("arst_async", 64'(dut_vec()), 64'd0);
      tick("arst_hold");
      reset = 0;
      repeat (3) tick("arst_idle");
      chk("arst_stays_idle", 64'(state), 64'd0);

      // Random stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         start = ($urandom_range(0, 15) == 0);
         stop  = ($urandom_range(0, 299) == 0);
         pause = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 1499) == 0);
         song_select = 5'($urandom);
         chart_red    = {$urandom, $urandom, $urandom, 4'($urandom)};
         chart_blue   = {$urandom, $urandom, $urandom, 4'($urandom)};
         chart_yellow = {$urandom, $urandom, $urandom, 4'($urandom)};
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
